vscale_dmem_arbiter: RTL and testbench
======================================

// Module: vscale_dmem_arbiter
// PURPOSE
//  Multicore shared-memory arbiter downstream of the per-core HASTI dmem masters (vscale_hasti_bridge outputs).
//  Merges NUM_CORES AHB-lite master ports onto one slave port with round-robin address-phase grant.
//  Tracks the data-phase owner and routes hwdata/hrdata/hresp accordingly.
//  Buffers a completed response when its master's next request loses arbitration.
// PARAMETERS
//  NUM_CORES   default 2   number of master ports, 2..8
//  IDX_W       default 1   owner/pointer index width, $clog2(NUM_CORES), min 1
// PORTS
//  clk        in   1                  core clock, all state on posedge
//  reset      in   1                  synchronous, active-high
//  m_haddr    in   NUM_CORES*32       master i address at [32*i +: 32]; same packing for all m_* buses
//  m_hwrite   in   NUM_CORES          write enable
//  m_hsize    in   NUM_CORES*3        transfer size
//  m_hburst   in   NUM_CORES*3        burst type (forwarded)
//  m_hmastlock in  NUM_CORES          locked-transfer request
//  m_hprot    in   NUM_CORES*4        protection (forwarded)
//  m_htrans   in   NUM_CORES*2        request when == NONSEQ
//  m_hwdata   in   NUM_CORES*32       write data, data phase
//  m_hrdata   out  NUM_CORES*32       read data to master
//  m_hready   out  NUM_CORES          per-master ready
//  m_hresp    out  NUM_CORES          per-master response (OKAY=0)
//  s_haddr/s_hwrite/s_hsize/s_hburst/s_hmastlock/s_hprot/s_htrans  out  single-master widths  slave address phase
//  s_hwdata   out  32                 slave write data
//  s_hrdata   in   32                 slave read data
//  s_hready   in   1                  slave ready
//  s_hresp    in   1                  slave response
// BEHAVIOUR
//  - req[i] = (m_htrans[i]==NONSEQ). gnt = first req at/after rr_ptr, cyclic; combinational, stable while masters hold.
//  - Slave address phase driven from gnt master; no req -> s_htrans=IDLE, other s_* addr signals 0.
//  - On s_hready=1: accepted = gnt valid; owner<=gnt, owner_v<=accepted; rr_ptr<=(gnt+1) mod NUM_CORES if accepted.
//    s_hready=0: owner, owner_v, rr_ptr hold.
//  - s_hwdata = m_hwdata[owner] when owner_v, else 0.
//  - m_hready[i]:
//    hold_v[i]: 0, except 1 in the cycle i is accepted (gnt==i, s_hready=1);
//    owner_v & owner==i: s_hready, but 0 if req[i] & not accepted-for-i (response captured, see below);
//    else: 0 if req[i] & not accepted-for-i, else 1.
//  - Capture: owner_v & owner==i & s_hready & req[i] & gnt!=i -> hold_rdata[i]<=s_hrdata, hold_resp[i]<=s_hresp, hold_v[i]<=1.
//    Cleared when i accepted; m_hrdata[i]/m_hresp[i] come from hold in that cycle.
//  - m_hrdata[i]/m_hresp[i]: hold when hold_v[i]; slave when owner_v & owner==i; else 0/OKAY.
//  - Latency: zero added cycles for an uncontended master (address and data pass combinationally).
//  - Contention: each losing master waits at most NUM_CORES-1 accepted grants.
//  - Simultaneous data-phase completion plus capture plus new grant to another master: all legal same cycle.
//  - Reset: owner_v=0, rr_ptr=0, hold_v=0, hold data 0, locked=0.
//    Outputs after reset: s_htrans per req, m_hready=1 for non-requesters, m_hresp=OKAY.
//    Reset mid-transfer drops owner; in-flight response discarded.
//  - ERROR response (hresp=1, two-cycle) passed to owner/held as-is; arbiter takes no recovery action.
// CONFIGURATION
//  VSCALE_DMEM_ARB_LOCK_EN defined:
//    accepted transfer with m_hmastlock=1 sets locked=1, lock_idx=gnt;
//    while locked, gnt forced to lock_idx (others stall);
//    locked clears on accepted transfer of lock_idx with hmastlock=0, or lock_idx IDLE address phase with s_hready=1.
//    s_hmastlock forwarded.
//  Undefined: m_hmastlock ignored, s_hmastlock=0, no lock state.
// TESTING
//  1. Single master 0 read, A=0x100, slave 1 wait state -> s_haddr=0x100 same cycle; m_hready[0] follows s_hready; m_hrdata[0]=s_hrdata.
//  2. Masters 0,1 NONSEQ same cycle after reset -> grants 0 then 1; rr_ptr 0->1->0; m_hready[1]=0 one cycle.
//  3. Master 0 back-to-back reads, 1 requesting, rr_ptr=1 -> m0 data 0xDEAD held; m_hready[0]=0 until granted.
//     On grant cycle m_hrdata[0]=0xDEAD.
//  4. Master 1 write 0xCAFE, addr 0x200 -> s_hwdata=0xCAFE in data phase only; master 0 hwdata never reaches slave.
//  5. Reset asserted during m0 data phase -> next cycle owner_v=0, hold_v=0, m_hready all 1 for idle masters.
//  6. LOCK_EN: m1 locked pair with m0 requesting -> m0 stalls both beats, granted after unlock; undefined: round-robin interleaves.

Source files
------------

// File: rtl/vscale_dmem_arbiter.sv
// Round-robin merge of NUM_CORES AHB-lite dmem masters onto one slave; address and data pass with zero added latency.
// Losers stall on m_hready and a finished response is parked until its next grant; bus lock under VSCALE_DMEM_ARB_LOCK_EN.
module vscale_dmem_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int IDX_W     = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CORES*32-1:0] m_haddr,
   input  logic [NUM_CORES-1:0]    m_hwrite,
   input  logic [NUM_CORES*3-1:0]  m_hsize,
   input  logic [NUM_CORES*3-1:0]  m_hburst,
   input  logic [NUM_CORES-1:0]    m_hmastlock,
   input  logic [NUM_CORES*4-1:0]  m_hprot,
   input  logic [NUM_CORES*2-1:0]  m_htrans,
   input  logic [NUM_CORES*32-1:0] m_hwdata,
   output logic [NUM_CORES*32-1:0] m_hrdata,
   output logic [NUM_CORES-1:0]    m_hready,
   output logic [NUM_CORES-1:0]    m_hresp,
   output logic [31:0]             s_haddr,
   output logic                    s_hwrite,
   output logic [2:0]              s_hsize,
   output logic [2:0]              s_hburst,
   output logic                    s_hmastlock,
   output logic [3:0]              s_hprot,
   output logic [1:0]              s_htrans,
   output logic [31:0]             s_hwdata,
   input  logic [31:0]             s_hrdata,
   input  logic                    s_hready,
   input  logic                    s_hresp
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   logic [NUM_CORES-1:0] w_req;
   logic [IDX_W-1:0]     w_rr_gnt;
   logic                 w_rr_gnt_v;
   logic [IDX_W-1:0]     w_gnt;
   logic                 w_gnt_v;
   logic                 w_acc;

   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     r_owner;
   logic                 r_owner_v;

   always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_CORES; i++)
         w_req[i] = (m_htrans[2*i +: 2] == HTRANS_NONSEQ);
   end

   // First requester at or after the round-robin pointer, wrapping around.
   always_comb begin
      w_rr_gnt   = '0;
      w_rr_gnt_v = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_rr_gnt_v && w_req[i] && (((k + int'(r_rr_ptr)) % NUM_CORES) == i)) begin
               w_rr_gnt   = IDX_W'(i);
               w_rr_gnt_v = 1'b1;
            end
         end
      end
   end

`ifdef VSCALE_DMEM_ARB_LOCK_EN
   logic             r_locked;
   logic [IDX_W-1:0] r_lock_idx;
   logic             w_lock_req;
   logic             w_gnt_lock;

   always_comb begin
      w_lock_req = 1'b0;
      for (int i = 0; i < NUM_CORES; i++)
         if (r_lock_idx == IDX_W'(i)) w_lock_req = w_req[i];
   end

   assign w_gnt   = r_locked ? r_lock_idx : w_rr_gnt;
   assign w_gnt_v = r_locked ? w_lock_req : w_rr_gnt_v;

   always_comb begin
      w_gnt_lock = 1'b0;
      for (int i = 0; i < NUM_CORES; i++)
         if (w_gnt == IDX_W'(i)) w_gnt_lock = m_hmastlock[i];
   end

   assign s_hmastlock = w_gnt_v & w_gnt_lock;

   // Lock is released by an unlocked beat from the holder or by the holder going idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_locked   <= 1'b0;
         r_lock_idx <= '0;
      end else if (w_acc && w_gnt_lock) begin
         r_locked   <= 1'b1;
         r_lock_idx <= w_gnt;
      end else if (r_locked && ((w_acc && !w_gnt_lock) || (!w_lock_req && s_hready))) begin
         r_locked   <= 1'b0;
      end
   end
`else
   logic w_unused_lock;

   assign w_gnt         = w_rr_gnt;
   assign w_gnt_v       = w_rr_gnt_v;
   assign s_hmastlock   = 1'b0;
   assign w_unused_lock = ^m_hmastlock;
`endif

   assign w_acc = w_gnt_v & s_hready;

   always_comb begin
      s_haddr  = '0;
      s_hwrite = 1'b0;
      s_hsize  = '0;
      s_hburst = '0;
      s_hprot  = '0;
      s_htrans = HTRANS_IDLE;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (w_gnt_v && (w_gnt == IDX_W'(i))) begin
            s_haddr  = m_haddr[32*i +: 32];
            s_hwrite = m_hwrite[i];
            s_hsize  = m_hsize[3*i +: 3];
            s_hburst = m_hburst[3*i +: 3];
            s_hprot  = m_hprot[4*i +: 4];
            s_htrans = m_htrans[2*i +: 2];
         end
      end
   end

   always_comb begin
      s_hwdata = '0;
      for (int i = 0; i < NUM_CORES; i++)
         if (r_owner_v && (r_owner == IDX_W'(i))) s_hwdata = m_hwdata[32*i +: 32];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner   <= '0;
         r_owner_v <= 1'b0;
         r_rr_ptr  <= '0;
      end else if (s_hready) begin
         r_owner   <= w_gnt;
         r_owner_v <= w_gnt_v;
         if (w_gnt_v)
            r_rr_ptr <= (w_gnt == IDX_W'(NUM_CORES - 1)) ? '0 : w_gnt + IDX_W'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_master
      logic        w_own;
      logic        w_acc_i;
      logic        w_stall;
      logic        w_cap;
      logic        r_hold_v;
      logic [31:0] r_hold_rdata;
      logic        r_hold_resp;

      assign w_own   = r_owner_v && (r_owner == IDX_W'(gi));
      assign w_acc_i = w_acc && (w_gnt == IDX_W'(gi));
      assign w_stall = w_req[gi] && !w_acc_i;
      // Our data phase finishes while our next request loses: park the response.
      assign w_cap   = w_own && s_hready && w_stall;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_hold_v     <= 1'b0;
            r_hold_rdata <= '0;
            r_hold_resp  <= 1'b0;
         end else if (w_cap) begin
            r_hold_v     <= 1'b1;
            r_hold_rdata <= s_hrdata;
            r_hold_resp  <= s_hresp;
         end else if (w_acc_i) begin
            r_hold_v     <= 1'b0;
         end
      end

      assign m_hready[gi] = r_hold_v ? w_acc_i :
                            w_own    ? (s_hready && !w_stall) : !w_stall;
      assign m_hrdata[32*gi +: 32] = r_hold_v ? r_hold_rdata :
                                     w_own    ? s_hrdata     : 32'h0;
      assign m_hresp[gi] = r_hold_v ? r_hold_resp :
                           w_own    ? s_hresp     : 1'b0;
   end

endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// Directed bench for vscale_dmem_arbiter (NUM_CORES=2); slave address phases are scoreboarded in expected grant order.
module tb_vscale_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic [63:0] m_haddr;
   logic [1:0]  m_hwrite;
   logic [5:0]  m_hsize;
   logic [5:0]  m_hburst;
   logic [1:0]  m_hmastlock;
   logic [7:0]  m_hprot;
   logic [3:0]  m_htrans;
   logic [63:0] m_hwdata;
   logic [63:0] m_hrdata;
   logic [1:0]  m_hready;
   logic [1:0]  m_hresp;
   logic [31:0] s_haddr;
   logic        s_hwrite;
   logic [2:0]  s_hsize;
   logic [2:0]  s_hburst;
   logic        s_hmastlock;
   logic [3:0]  s_hprot;
   logic [1:0]  s_htrans;
   logic [31:0] s_hwdata;
   logic [31:0] s_hrdata;
   logic        s_hready;
   logic        s_hresp;

   logic [31:0] haddr [2];
   logic        hwrite[2];
   logic        hlock [2];
   logic [1:0]  htrans[2];
   logic [31:0] hwdata[2];

   int          n_checks = 0;
   int          n_errors = 0;
   logic [32:0] sb[$];

   assign m_haddr     = {haddr[1], haddr[0]};
   assign m_hwrite    = {hwrite[1], hwrite[0]};
   assign m_hmastlock = {hlock[1], hlock[0]};
   assign m_htrans    = {htrans[1], htrans[0]};
   assign m_hwdata    = {hwdata[1], hwdata[0]};
   assign m_hsize     = {3'd2, 3'd2};
   assign m_hburst    = {3'd0, 3'd0};
   assign m_hprot     = {4'h5, 4'hA};

   vscale_dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hmastlock(m_hmastlock), .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hwdata(m_hwdata),
      .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
      .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle, then retire any accepted slave address phase.
   task automatic eval();
      logic [32:0] e;
      #2;
      if (s_htrans == 2'b10 && s_hready) begin
         n_checks++;
         assert (sb.size() > 0) else begin
            n_errors++;
            $error("FAIL sb_grant observed=%h expected=none", s_haddr);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_addr", {31'h0, s_hwrite, s_haddr}, {31'h0, e});
         end
      end
   endtask

   task automatic req(input int i, input logic [31:0] a, input logic w, input logic lk);
      haddr[i]  = a;
      hwrite[i] = w;
      hlock[i]  = lk;
      htrans[i] = 2'b10;
   endtask

   task automatic idle(input int i);
      haddr[i]  = '0;
      hwrite[i] = 1'b0;
      hlock[i]  = 1'b0;
      htrans[i] = 2'b00;
   endtask

   initial begin
      reset = 1'b1;
      idle(0);
      idle(1);
      hwdata[0] = 32'h0000_BAD0;
      hwdata[1] = 32'h0;
      s_hready  = 1'b1;
      s_hrdata  = '0;
      s_hresp   = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      reset = 1'b0;
      eval();
      chk("rst_hready", m_hready, 2'b11);
      chk("rst_hresp", m_hresp, 2'b00);
      chk("rst_htrans", s_htrans, 2'b00);
      chk("rst_haddr", s_haddr, 32'h0);
      chk("rst_hwdata", s_hwdata, 32'h0);
      chk("rst_hrdata", m_hrdata, 64'h0);

      // single master read with one slave wait state
      nxt(); req(0, 32'h100, 1'b0, 1'b0); sb.push_back({1'b0, 32'h100}); eval();
      chk("t1_haddr", s_haddr, 32'h100);
      chk("t1_htrans", s_htrans, 2'b10);
      chk("t1_hready_a", m_hready, 2'b11);
      nxt(); idle(0); s_hready = 1'b0; s_hrdata = 32'h1111_1111; eval();
      chk("t1_hready_wait", m_hready, 2'b10);
      nxt(); s_hready = 1'b1; s_hrdata = 32'h1234_5678; eval();
      chk("t1_hready_done", m_hready, 2'b11);
      chk("t1_rdata0", m_hrdata[31:0], 32'h1234_5678);
      chk("t1_rdata1", m_hrdata[63:32], 32'h0);

      // simultaneous requests after reset: 0 then 1, pointer wraps back to 0
      nxt(); reset = 1'b1; s_hrdata = '0; eval();
      nxt(); reset = 1'b0; req(0, 32'h300, 1'b0, 1'b0); req(1, 32'h400, 1'b0, 1'b0);
      sb.push_back({1'b0, 32'h300}); sb.push_back({1'b0, 32'h400}); eval();
      chk("t2_haddr0", s_haddr, 32'h300);
      chk("t2_hprot0", s_hprot, 4'hA);
      chk("t2_hready0", m_hready, 2'b01);
      nxt(); idle(0); s_hrdata = 32'hA0A0_0000; eval();
      chk("t2_haddr1", s_haddr, 32'h400);
      chk("t2_hprot1", s_hprot, 4'h5);
      chk("t2_hready1", m_hready, 2'b11);
      chk("t2_rdata0", m_hrdata[31:0], 32'hA0A0_0000);
      nxt(); idle(1); s_hrdata = 32'hB0B0_0000; eval();
      chk("t2_rdata1", m_hrdata[63:32], 32'hB0B0_0000);
      chk("t2_hready2", m_hready, 2'b11);

      // back-to-back reads from 0 while 1 waits: 0's response parked
      nxt(); req(0, 32'h500, 1'b0, 1'b0); req(1, 32'h600, 1'b0, 1'b0); s_hrdata = '0;
      sb.push_back({1'b0, 32'h500}); sb.push_back({1'b0, 32'h600}); eval();
      chk("t3_haddr_wrap", s_haddr, 32'h500);
      chk("t3_hready_a", m_hready, 2'b01);
      nxt(); req(0, 32'h504, 1'b0, 1'b0); s_hrdata = 32'h0000_DEAD;
      sb.push_back({1'b0, 32'h504}); eval();
      chk("t3_haddr1", s_haddr, 32'h600);
      chk("t3_hready_cap", m_hready, 2'b10);
      nxt(); idle(1); s_hready = 1'b0; s_hrdata = 32'hFFFF_0000; eval();
      chk("t3_hready_wait", m_hready, 2'b00);
      chk("t3_haddr_wait", s_haddr, 32'h504);
      chk("t3_held_wait", m_hrdata[31:0], 32'h0000_DEAD);
      nxt(); s_hready = 1'b1; s_hrdata = 32'h0000_BEEF; eval();
      chk("t3_hready_rel", m_hready, 2'b11);
      chk("t3_held_rdata", m_hrdata[31:0], 32'h0000_DEAD);
      chk("t3_rdata1", m_hrdata[63:32], 32'h0000_BEEF);
      nxt(); idle(0); s_hrdata = 32'h0000_5040; eval();
      chk("t3_rdata0_next", m_hrdata[31:0], 32'h0000_5040);

      // write from master 1; master 0 data never reaches the slave
      nxt(); req(1, 32'h200, 1'b1, 1'b0); s_hrdata = '0; sb.push_back({1'b1, 32'h200}); eval();
      chk("t4_hwrite", s_hwrite, 1'b1);
      chk("t4_hwdata_addr", s_hwdata, 32'h0);
      nxt(); idle(1); hwdata[1] = 32'h0000_CAFE; eval();
      chk("t4_hwdata_data", s_hwdata, 32'h0000_CAFE);
      chk("t4_hready", m_hready, 2'b11);
      nxt(); eval();
      chk("t4_hwdata_after", s_hwdata, 32'h0);

      // reset while 1 owns the data phase and 0 holds a parked response
      nxt(); req(0, 32'h700, 1'b0, 1'b0); sb.push_back({1'b0, 32'h700}); eval();
      nxt(); req(0, 32'h704, 1'b0, 1'b0); req(1, 32'h800, 1'b1, 1'b0); s_hrdata = 32'h0000_7777;
      sb.push_back({1'b1, 32'h800}); eval();
      chk("t5_hready_cap", m_hready, 2'b10);
      nxt(); idle(0); idle(1); reset = 1'b1; s_hready = 1'b0; s_hrdata = '0; eval();
      chk("t5_held_pre", m_hrdata[31:0], 32'h0000_7777);
      nxt(); reset = 1'b0; s_hready = 1'b1; s_hrdata = 32'h0000_9999; eval();
      chk("t5_hready", m_hready, 2'b11);
      chk("t5_hrdata", m_hrdata, 64'h0);
      chk("t5_hresp", m_hresp, 2'b00);
      chk("t5_hwdata", s_hwdata, 32'h0);

      // two-cycle ERROR response passed to the owner
      nxt(); req(1, 32'h900, 1'b0, 1'b0); s_hrdata = '0; sb.push_back({1'b0, 32'h900}); eval();
      nxt(); idle(1); s_hready = 1'b0; s_hresp = 1'b1; eval();
      chk("err_hresp1", m_hresp, 2'b10);
      chk("err_hready1", m_hready, 2'b01);
      nxt(); s_hready = 1'b1; eval();
      chk("err_hresp2", m_hresp, 2'b10);
      chk("err_hready2", m_hready, 2'b11);
      nxt(); s_hresp = 1'b0; eval();
      chk("err_clear", m_hresp, 2'b00);

      // locked pair from master 1 while master 0 requests
      nxt(); req(1, 32'hA00, 1'b0, 1'b1); sb.push_back({1'b0, 32'hA00}); eval();
      chk("t6_hready_a", m_hready, 2'b11);
`ifdef VSCALE_DMEM_ARB_LOCK_EN
      chk("t6_hmastlock", s_hmastlock, 1'b1);
      nxt(); req(1, 32'hA04, 1'b0, 1'b1); req(0, 32'hB00, 1'b0, 1'b0); s_hrdata = 32'h0000_0A00;
      sb.push_back({1'b0, 32'hA04}); eval();
      chk("t6_haddr_beat2", s_haddr, 32'hA04);
      chk("t6_hready_beat2", m_hready, 2'b10);
      chk("t6_rdata1_a", m_hrdata[63:32], 32'h0000_0A00);
      nxt(); idle(1); s_hrdata = 32'h0000_0A04; eval();
      chk("t6_htrans_lock", s_htrans, 2'b00);
      chk("t6_hready_lock", m_hready, 2'b10);
      chk("t6_rdata1_b", m_hrdata[63:32], 32'h0000_0A04);
      nxt(); s_hrdata = '0; sb.push_back({1'b0, 32'hB00}); eval();
      chk("t6_haddr_unlock", s_haddr, 32'hB00);
      chk("t6_hready_unlock", m_hready, 2'b11);
      nxt(); idle(0); s_hrdata = 32'h0000_B0B0; eval();
      chk("t6_rdata0", m_hrdata[31:0], 32'h0000_B0B0);
`else
      chk("t6_hmastlock", s_hmastlock, 1'b0);
      nxt(); req(1, 32'hA04, 1'b0, 1'b1); req(0, 32'hB00, 1'b0, 1'b0); s_hrdata = 32'h0000_0A00;
      sb.push_back({1'b0, 32'hB00}); eval();
      chk("t6_haddr_rr", s_haddr, 32'hB00);
      chk("t6_hready_rr", m_hready, 2'b01);
      nxt(); idle(0); s_hrdata = 32'h0000_B0B0; sb.push_back({1'b0, 32'hA04}); eval();
      chk("t6_haddr_beat2", s_haddr, 32'hA04);
      chk("t6_hready_beat2", m_hready, 2'b11);
      chk("t6_rdata0", m_hrdata[31:0], 32'h0000_B0B0);
      chk("t6_held_rdata1", m_hrdata[63:32], 32'h0000_0A00);
      nxt(); idle(1); s_hrdata = 32'h0000_0A04; eval();
      chk("t6_rdata1_b", m_hrdata[63:32], 32'h0000_0A04);
`endif

      nxt(); s_hrdata = '0; eval();
      chk("sb_drained", 64'(sb.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
